// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the phase sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEMORY  = 3'd4,
    ST_WRITE   = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_IMEM  = 2'b01;
  localparam logic [1:0] FAULT_ALIGN = 2'b10;
  localparam logic [1:0] FAULT_DMEM  = 2'b11;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Wait-state timer shared by the instruction and data memory handshakes.
// expired is asserted during the MAX_WAIT-th consecutive counting cycle.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Count cycles spent waiting; saturate so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != CW'(MAX_WAIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the cycles already elapsed, so the current cycle is cnt+1.
  assign expired = count && (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Handshaked multi-cycle phase sequencer and program counter.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                CNT_W        = 32,
  parameter int                MAX_WAIT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             is_mem_op,
  input  logic             is_halt_op,
  input  logic             jump_en,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             reg_write_en,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_cause
);

  state_t     state, next_state;
  logic       mem_pass;
  logic       retire;
  logic [1:0] fault_set;
  logic       misaligned;
  logic       tmr_clear, tmr_count, tmr_expired;

  assign pc_plus4   = pc + XLEN'(INSTR_BYTES);
  assign misaligned = jump_en && (jump_target[1:0] != 2'b00);
  assign halted     = (state == ST_HALT);
  assign fault      = (fault_cause != FAULT_NONE);

  // One timer serves both handshakes; it is held clear outside FETCH/MEMORY
  // so each entry starts from zero.
  assign tmr_count = (state == ST_FETCH) || (state == ST_MEMORY);
  assign tmr_clear = !tmr_count;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic and Moore phase enables; wb_en also gated by reg_write_en.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    if_en      = 1'b0;
    id_en      = 1'b0;
    exe_en     = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    retire     = 1'b0;
    fault_set  = FAULT_NONE;
    case (state)
      ST_IDLE: begin
        if (run && (!step_mode || step_req)) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if_en    = 1'b1;
        if (imem_ack) begin
          next_state = ST_DECODE;
        end else if (tmr_expired) begin
          next_state = ST_HALT;
          fault_set  = FAULT_IMEM;
        end
      end
      ST_DECODE: begin
        id_en      = 1'b1;
        next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exe_en     = 1'b1;
        next_state = is_mem_op ? ST_MEMORY : ST_WRITE;
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        mem_en   = 1'b1;
        if (dmem_ack) begin
          next_state = ST_WRITE;
        end else if (tmr_expired) begin
          next_state = ST_HALT;
          fault_set  = FAULT_DMEM;
        end
      end
      ST_WRITE: begin
        mem_en = mem_pass;
        if (misaligned) begin
          next_state = ST_HALT;
          fault_set  = FAULT_ALIGN;
        end else begin
          wb_en  = reg_write_en;
          retire = 1'b1;
          if (is_halt_op)     next_state = ST_HALT;
          else if (step_mode) next_state = ST_IDLE;
          else                next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Architectural state: PC, retired count, fault cause and MEMORY-visit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      retired     <= '0;
      fault_cause <= FAULT_NONE;
      mem_pass    <= 1'b0;
    end else begin
      if (retire) begin
        pc      <= jump_en ? jump_target : pc_plus4;
        retired <= retired + CNT_W'(1);
      end
      if (state == ST_EXECUTE) mem_pass <= is_mem_op;
      if (fault_set != FAULT_NONE) fault_cause <= fault_set;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, step_mode, step_req;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic        is_mem_op, is_halt_op, jump_en, reg_write_en;
  logic [31:0] jump_target;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [31:0] pc, pc_plus4, retired;
  logic        halted, fault;
  logic [1:0]  fault_cause;

  int nvec = 0;
  int nmis = 0;

  cpu_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h100), .CNT_W(32), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step_req(step_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .is_mem_op(is_mem_op), .is_halt_op(is_halt_op), .jump_en(jump_en),
    .jump_target(jump_target), .reg_write_en(reg_write_en),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .halted(halted),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h100);
    chk({tag, "_ret"}, retired, 0);
    chk({tag, "_halt"}, halted, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_cause"}, fault_cause, 0);
    chk({tag, "_en"}, {imem_req, dmem_req, if_en, id_en, exe_en, mem_en, wb_en}, 7'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int wb_cnt, dreq_cnt;
    rst = 1'b1; run = 1'b1; step_mode = 1'b0; step_req = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b0; is_mem_op = 1'b0; is_halt_op = 1'b0;
    jump_en = 1'b0; jump_target = 32'h0; reg_write_en = 1'b1;

    // Straight-line non-memory instructions, zero-wait fetch.
    do_reset("rst0");
    step();
    for (int i = 0; i < 3; i++) begin
      chk("seq_if", if_en, 1);
      chk("seq_pc", pc, 32'h100 + 32'(4 * i));
      chk("seq_pc4", pc_plus4, 32'h104 + 32'(4 * i));
      step();
      chk("seq_id", id_en, 1);
      step();
      chk("seq_exe", exe_en, 1);
      step();
      chk("seq_wb", wb_en, 1);
      step();
    end
    chk("seq_ret3", retired, 3);
    chk("seq_pc3", pc, 32'h10C);

    // Load with dmem_ack delayed 3 cycles: 8 cycles FETCH to FETCH.
    is_mem_op = 1'b1;
    wb_cnt = 0;
    dreq_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      dmem_ack = (c == 6);
      wb_cnt += int'(wb_en);
      dreq_cnt += int'(dmem_req);
      if (c == 7) chk("ld_mem_en_wr", mem_en, 1);
      step();
    end
    dmem_ack = 1'b0;
    is_mem_op = 1'b0;
    chk("ld_wb_once", wb_cnt, 1);
    chk("ld_dreq4", dreq_cnt, 4);
    chk("ld_back_fetch", if_en, 1);
    chk("ld_pc", pc, 32'h110);
    chk("ld_ret", retired, 4);

    // Aligned jump, then misaligned jump faults.
    jump_en = 1'b1; jump_target = 32'h200;
    repeat (4) step();
    chk("jmp_pc", pc, 32'h200);
    chk("jmp_ret", retired, 5);
    jump_target = 32'h202;
    repeat (3) step();
    chk("mis_wb_forced0", wb_en, 0);
    step();
    chk("mis_halt", halted, 1);
    chk("mis_cause", fault_cause, 2'b10);
    chk("mis_fault", fault, 1);
    chk("mis_pc", pc, 32'h200);
    chk("mis_ret", retired, 5);
    repeat (3) step();
    chk("halt_sticky", {halted, if_en, imem_req}, 3'b100);
    jump_en = 1'b0;

    // Instruction fetch timeout after 15 FETCH cycles.
    imem_ack = 1'b0;
    do_reset("rst1");
    step();
    repeat (14) step();
    chk("to_still_fetch", if_en, 1);
    step();
    chk("to_halt", halted, 1);
    chk("to_cause", fault_cause, 2'b01);
    chk("to_pc", pc, 32'h100);

    // Ack on the 15th FETCH cycle wins over the timeout.
    do_reset("rst2");
    step();
    repeat (14) step();
    imem_ack = 1'b1;
    step();
    chk("late_ack_id", id_en, 1);
    chk("late_ack_nohalt", halted, 0);
    chk("late_ack_cause", fault_cause, 0);

    // Single-step mode; a step_req outside IDLE is dropped.
    step_mode = 1'b1;
    do_reset("rst3");
    repeat (3) step();
    chk("stp_wait_idle", if_en, 0);
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    chk("stp_fetch", if_en, 1);
    step();
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    step();
    chk("stp_write", wb_en, 1);
    step();
    chk("stp_ret1", retired, 1);
    chk("stp_pc", pc, 32'h104);
    repeat (3) step();
    chk("stp_idle_hold", {if_en, id_en, halted}, 3'b000);
    chk("stp_ret_hold", retired, 1);

    // ECALL retires then halts without a fault.
    is_halt_op = 1'b1;
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    repeat (3) step();
    step();
    chk("ecall_halt", halted, 1);
    chk("ecall_fault", fault, 0);
    chk("ecall_ret", retired, 2);
    chk("ecall_pc", pc, 32'h108);
    is_halt_op = 1'b0;

    // Reset pulsed during MEMORY aborts the instruction at once.
    step_mode = 1'b0;
    is_mem_op = 1'b1;
    dmem_ack = 1'b0;
    do_reset("rst4");
    step();
    repeat (3) step();
    chk("mr_in_mem", dmem_req, 1);
    do_reset("mr_abort");
    chk("mr_idle", if_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle phase sequencer and program counter for the RISC-V core. It replaces the fixed free-running phase machine with a handshaked sequencer, and it owns the PC and the per-phase enables for instruction memory, decode, register file, data memory and write-back. Instruction and data memory get wait-state handshakes with a timeout. The block skips the MEMORY phase for non-memory instructions, supports halt, single-step and fault detection, and keeps a retired-instruction counter.

## Interface
- XLEN, 32: PC and jump-target width.
- RESET_VECTOR, 0: PC value after reset.
- CNT_W, 32: retired-instruction counter width.
- MAX_WAIT, 15: maximum wait cycles per memory handshake before a fault; ≥1.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  allows leaving IDLE.
- step_mode  input  1  1 = pause in IDLE after every retired instruction.
- step_req  input  1  single-cycle pulse releasing one instruction in step mode.
- imem_req  output  1  instruction fetch request.
- imem_ack  input  1  instruction word valid.
- dmem_req  output  1  data access request.
- dmem_ack  input  1  data access complete.
- is_mem_op  input  1  decoded instruction is a load/store; sampled in EXECUTE.
- is_halt_op  input  1  decoded ECALL/EBREAK; sampled in WRITE.
- jump_en  input  1  taken branch/jump; sampled in WRITE.
- jump_target  input  XLEN  next PC when jump_en.
- reg_write_en  input  1  instruction writes rd.
- if_en, id_en, exe_en, mem_en, wb_en  output  1 each  phase enables.
- pc  output  XLEN  current PC.
- pc_plus4  output  XLEN  pc + 4, modulo 2^XLEN.
- retired  output  CNT_W  retired-instruction count.
- halted  output  1  sequencer in HALT.
- fault  output  1  HALT was entered through a fault.
- fault_cause  output  2  00 none, 01 imem timeout, 10 misaligned target, 11 dmem timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITE, HALT.
- IDLE → FETCH when run && (!step_mode || step_req). Otherwise the sequencer stays in IDLE.
- FETCH: imem_req=1, if_en=1.
  - → DECODE on imem_ack.
  - → HALT with cause 01 if MAX_WAIT cycles pass without ack.
- DECODE → EXECUTE unconditionally; id_en=1.
- EXECUTE: exe_en=1. → MEMORY if is_mem_op, else → WRITE.
- MEMORY: dmem_req=1, mem_en=1.
  - → WRITE on dmem_ack.
  - → HALT with cause 11 on timeout.
- WRITE: wb_en = reg_write_en. mem_en=1 if the instruction passed through MEMORY.
  - Misaligned jump (jump_en && jump_target[1:0]≠0): → HALT with cause 10. PC is unchanged, retired does not increment, wb_en is forced to 0.
  - Otherwise:
    - pc ← jump_en ? jump_target : pc_plus4.
    - retired increments, wrapping modulo 2^CNT_W.
    - Next state: is_halt_op → HALT (halt op retires; PC still advances); else step_mode → IDLE; else → FETCH.
- HALT is terminal: halted=1, all enables and requests are 0, and the block leaves HALT only on rst. fault=1 iff fault_cause≠00.
- An ack arriving outside FETCH/MEMORY is ignored. A step_req arriving outside IDLE is dropped, not queued.

## Timing
- Reset values: state IDLE, pc=RESET_VECTOR, retired=0, halted=0, fault=0, fault_cause=00, all enables and requests 0.
- Reset asserted mid-instruction aborts it immediately: no PC or counter update, no write-back.
- Enables and requests are Moore outputs decoded from the state register, except wb_en, which is gated by reg_write_en.
- Zero-wait ack (ack in the first cycle of the request) is legal.
  - Minimum latency: 4 cycles for a non-memory instruction, 5 for load/store.
  - Each wait cycle adds 1.
- Wait counter clears on entry to FETCH/MEMORY. Timeout fires on the cycle the counter reaches MAX_WAIT with ack still low. Ack in that same cycle wins.
- pc and retired update on the clock edge that leaves WRITE.

## Structure
- Package cpu_seq_pkg:
  - state enum encoding;
  - fault-cause constants FAULT_NONE, FAULT_IMEM, FAULT_ALIGN, FAULT_DMEM;
  - INSTR_BYTES = 4.
- One sub-module, wait_timer: parametrised by MAX_WAIT, with clear and count inputs and an expired output. It is instantiated once and shared by FETCH and MEMORY.

## Test plan
- Reset with RESET_VECTOR=0x100, run=1, imem_ack tied 1, non-memory instructions → pc 0x100, 0x104, 0x108 at 4-cycle spacing; retired=3 after 12 cycles.
- Load with dmem_ack delayed 3 cycles → 8 cycles FETCH-to-FETCH; wb_en high exactly one cycle.
- jump_en with jump_target=0x200 → pc=0x200. With jump_target=0x202 → halted=1, fault_cause=10, pc unchanged, retired unchanged.
- imem_ack held 0, MAX_WAIT=15 → HALT with cause 01 after 15 FETCH cycles. Ack arriving on cycle 15 → DECODE, no fault.
- step_mode=1, one step_req pulse → exactly one instruction retires, then the sequencer returns to IDLE. ECALL in WRITE → HALT, fault=0, retired incremented.
- rst pulsed during MEMORY → all outputs return to reset values in the same cycle, with no write-back.
